// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU execute unit (op encodings, decoded
// operation set, control FSM states). The MUL encoding is only reachable
// when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_ILL  = 2'b11;

  typedef enum logic [3:0] {
    CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_XOR, CTRL_SLL,
    CTRL_SRL, CTRL_SRA, CTRL_SLT, CTRL_SLTU, CTRL_MUL, CTRL_ILL
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DONE
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bus of the ALU execute unit.
// master = issuing stage (decode side), slave = the execute unit.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7b5, funct7b0, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7b5, funct7b0, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct3/funct7 -> alu_ctrl_e.
// With ALU_MUL_EN undefined the MUL encoding decodes as illegal.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_funct7b0,
  output alu_ctrl_e  o_ctrl
);

  // decode table; any M-extension encoding other than MUL is illegal
  always_comb begin
    o_ctrl = CTRL_ILL;
    case (i_alu_op)
      ALUOP_ADD: o_ctrl = CTRL_ADD;
      ALUOP_SUB: o_ctrl = CTRL_SUB;
      ALUOP_FUNC: begin
        if (i_funct7b0) begin
`ifdef ALU_MUL_EN
          o_ctrl = (i_funct3 == 3'b000) ? CTRL_MUL : CTRL_ILL;
`else
          o_ctrl = CTRL_ILL;
`endif
        end else begin
          case (i_funct3)
            3'b000:  o_ctrl = i_funct7b5 ? CTRL_SUB : CTRL_ADD;
            3'b001:  o_ctrl = CTRL_SLL;
            3'b010:  o_ctrl = CTRL_SLT;
            3'b011:  o_ctrl = CTRL_SLTU;
            3'b100:  o_ctrl = CTRL_XOR;
            3'b101:  o_ctrl = i_funct7b5 ? CTRL_SRA : CTRL_SRL;
            3'b110:  o_ctrl = CTRL_OR;
            default: o_ctrl = CTRL_AND;
          endcase
        end
      end
      default: o_ctrl = CTRL_ILL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU with valid/ready handshake. Single-cycle ops
// register their result one cycle after accept. Define ALU_MUL_EN to add
// a shift-add multiplier (one op_b bit per cycle, XLEN iterations).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic            r_zero, r_illegal;
  alu_ctrl_e       w_ctrl;
  logic            w_in_ready, w_out_valid, w_accept, w_is_mul, w_mul_last;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_res;

  alu_ctrl_decode u_dec (
    .i_alu_op   (bus.alu_op),
    .i_funct3   (bus.funct3),
    .i_funct7b5 (bus.funct7b5),
    .i_funct7b0 (bus.funct7b0),
    .o_ctrl     (w_ctrl)
  );

  assign w_shamt  = bus.op_b[SHW-1:0];
  assign w_accept = bus.in_valid & w_in_ready;

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] r_mcand, r_mplier, r_acc, w_mul_sum;
  logic [SHW-1:0]  r_cnt;

  assign w_is_mul   = (w_ctrl == CTRL_MUL);
  assign w_mul_last = (r_state == ST_MUL) && (r_cnt == SHW'(XLEN - 1));
  assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);

  // shift-add multiplier: consume one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= bus.op_a;
      r_mplier <= bus.op_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_mul_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_last = 1'b0;
`endif

  // single-cycle datapath; MUL/ILL produce 0 here
  always_comb begin
    w_alu_res = '0;
    case (w_ctrl)
      CTRL_ADD:  w_alu_res = bus.op_a + bus.op_b;
      CTRL_SUB:  w_alu_res = bus.op_a - bus.op_b;
      CTRL_AND:  w_alu_res = bus.op_a & bus.op_b;
      CTRL_OR:   w_alu_res = bus.op_a | bus.op_b;
      CTRL_XOR:  w_alu_res = bus.op_a ^ bus.op_b;
      CTRL_SLL:  w_alu_res = bus.op_a << w_shamt;
      CTRL_SRL:  w_alu_res = bus.op_a >> w_shamt;
      CTRL_SRA:  w_alu_res = $unsigned($signed(bus.op_a) >>> w_shamt);
      CTRL_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      CTRL_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      default:   w_alu_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; DONE can re-accept in the same cycle the result drains
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
`ifdef ALU_MUL_EN
      ST_MUL:  if (w_mul_last) w_state_nxt = ST_DONE;
`endif
      ST_DONE: if (bus.out_ready)
                 w_state_nxt = w_accept ? (w_is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; in_ready is forced low while reset is asserted
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = rst_n;
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = rst_n & bus.out_ready;
      end
      default: ;
    endcase
  end

  // result registers only change on accept or MUL completion, so they hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_result  <= w_alu_res;
      r_zero    <= (w_alu_res == '0);
      r_illegal <= (w_ctrl == CTRL_ILL);
    end
`ifdef ALU_MUL_EN
    else if (w_mul_last) begin
      r_result <= w_mul_sum;
      r_zero   <= (w_mul_sum == '0);
    end
`endif
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with literal expectations, plus a
// queue-based reference model checked every cycle. Honors ALU_MUL_EN.
module tb_alu_exec_unit;

  localparam int XLEN = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();
  alu_exec_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          due;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // what the unit must produce for a request, straight from the op definitions
  function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3,
                                 input logic b5, input logic b0,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = 32'h0; e.ill = 1'b0; e.lat = 1; e.due = 0;
    if (aop == 2'b00)      e.res = a + b;
    else if (aop == 2'b01) e.res = a - b;
    else if (aop == 2'b11) e.ill = 1'b1;
    else if (b0) begin
      if (f3 == 3'd0 && MUL_EN) begin e.res = a * b; e.lat = XLEN + 1; end
      else e.ill = 1'b1;
    end else begin
      case (f3)
        3'd0: e.res = b5 ? a - b : a + b;
        3'd1: e.res = a << b[4:0];
        3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ b;
        3'd5: e.res = b5 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end
    return e;
  endfunction

  // per-cycle compare against the model queue
  always @(negedge clk) begin
    logic ev, er;
    exp_t e;
    if (!rst_n) begin
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst result",    bus.result,         32'd0);
      chk("rst zero",      32'(bus.zero),      32'd0);
      chk("rst illegal",   32'(bus.illegal),   32'd0);
      q.delete();
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].due);
      er = (q.size() == 0) || (ev && bus.out_ready);
      chk("mdl out_valid", 32'(bus.out_valid), 32'(ev));
      chk("mdl in_ready",  32'(bus.in_ready),  32'(er));
      if (ev) begin
        chk("mdl result",  bus.result,        q[0].res);
        chk("mdl zero",    32'(bus.zero),     32'(q[0].res == 32'h0));
        chk("mdl illegal", 32'(bus.illegal),  32'(q[0].ill));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && er) begin
        e = model(bus.alu_op, bus.funct3, bus.funct7b5, bus.funct7b0, bus.op_a, bus.op_b);
        e.due = cyc + e.lat;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic b5,
                       input logic b0, input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = aop; bus.funct3 = f3; bus.funct7b5 = b5; bus.funct7b0 = b0;
    bus.op_a = a; bus.op_b = b;
  endtask

  // issue one op with out_ready=1, check latency and literal result
  task automatic do_op(input string nm, input logic [1:0] aop, input logic [2:0] f3,
                       input logic b5, input logic b0, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_ill, input int exp_lat);
    int k;
    @(posedge clk); #1;
    drive(aop, f3, b5, b0, a, b);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.in_ready && k < 100);
    if (!bus.in_ready) begin
      chk({nm, " accept timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.out_valid && k < 100);
    chk({nm, " latency"}, 32'(k), 32'(exp_lat));
    chk({nm, " result"},  bus.result, exp_res);
    chk({nm, " zero"},    32'(bus.zero), 32'(exp_res == 32'h0));
    chk({nm, " illegal"}, 32'(bus.illegal), 32'(exp_ill));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset result",   bus.result,        32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // add/sub and funct-decoded ops
    do_op("add 7+5",     2'b00, 3'd0, 1'b0, 1'b0, 32'd7,        32'd5,        32'd12,       1'b0, 1);
    do_op("sub 5-5",     2'b01, 3'd0, 1'b0, 1'b0, 32'd5,        32'd5,        32'd0,        1'b0, 1);
    do_op("add wrap",    2'b00, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
    do_op("sra",         2'b10, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
    do_op("srl",         2'b10, 3'd5, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
    do_op("slt",         2'b10, 3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    do_op("sltu",        2'b10, 3'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
    do_op("func sub",    2'b10, 3'd0, 1'b1, 1'b0, 32'd3,        32'd10,       32'hFFFFFFF9, 1'b0, 1);
    do_op("sll 31",      2'b10, 3'd1, 1'b0, 1'b0, 32'd1,        32'h0000003F, 32'h80000000, 1'b0, 1);
    do_op("or",          2'b10, 3'd6, 1'b0, 1'b0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1);
    do_op("illegal op",  2'b11, 3'd0, 1'b0, 1'b0, 32'd5,        32'd5,        32'd0,        1'b1, 1);
    do_op("illegal m",   2'b10, 3'd1, 1'b0, 1'b1, 32'd5,        32'd5,        32'd0,        1'b1, 1);
`ifdef ALU_MUL_EN
    do_op("mul 3x4",     2'b10, 3'd0, 1'b0, 1'b1, 32'd3,        32'd4,        32'd12,       1'b0, 33);
    do_op("mul big",     2'b10, 3'd0, 1'b0, 1'b1, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 33);
`else
    do_op("mul disabled",2'b10, 3'd0, 1'b0, 1'b1, 32'd3,        32'd4,        32'd0,        1'b1, 1);
`endif

    // backpressure: XOR held for 3 cycles, then AND accepted back-to-back
    @(posedge clk); #1;
    drive(2'b10, 3'd4, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk); chk("bp accept ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp hold valid",  32'(bus.out_valid), 32'd1);
      chk("bp hold result", bus.result,         32'h0FF00FF0);
      chk("bp hold ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    drive(2'b10, 3'd7, 1'b0, 1'b0, 32'hFFFF0000, 32'h00FFFF00);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b in_ready",   32'(bus.in_ready), 32'd1);
    chk("b2b old result", bus.result,        32'h0FF00FF0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b valid",  32'(bus.out_valid), 32'd1);
    chk("b2b result", bus.result,         32'h00FF0000);

    // reset while a result is being held
    @(posedge clk); #1;
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk); chk("hold pre-rst", bus.result, 32'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst done valid",  32'(bus.out_valid), 32'd0);
    chk("rst done result", bus.result,         32'd0);
    @(posedge clk); #1 rst_n = 1'b1; bus.out_ready = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.out_valid) seen++; end
    chk("no valid after rst", 32'(seen), 32'd0);

`ifdef ALU_MUL_EN
    // reset in the middle of a multiply aborts it
    @(posedge clk); #1;
    drive(2'b10, 3'd0, 1'b0, 1'b1, 32'd7, 32'd9);
    bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mulrst valid",  32'(bus.out_valid), 32'd0);
    chk("mulrst result", bus.result,         32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
    chk("mulrst no result", 32'(seen), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
